e_muldiv: RTL and testbench
===========================

Name: e_muldiv

Overview:
Execute-stage multiply/divide unit. It consumes the E-stage operands and the 4-bit MulDivOp held in the D→E pipeline register, and owns the HI/LO architectural registers. It models multi-cycle mult/div latency with a busy counter. Its Start/Busy outputs drive the D-stage stall logic, and MD_Out feeds the E-stage result mux for mfhi/mflo.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high after a mult-class start (≥1)
DIV_CYCLES, 10, cycles Busy stays high after a div-class start (≥1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
E_Valid  input  1  E-stage instruction is live; 0 (bubble/flush) forces op to NOP
E_MulDivOp  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-12 MADD/MADDU/MSUB/MSUBU (optional), 13-15 NOP
E_RS  input  32  forwarded operand A (dividend / multiplicand / mt source)
E_RT  input  32  forwarded operand B (divisor / multiplier)
Start  output  1  combinational: E_Valid & op is mult/div class & !Busy
Busy  output  1  registered: operation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register
MD_Out  output  32  combinational: HI if op==MFHI, LO if op==MFLO, else 0

Behaviour:
- Reset (rst low, any time, including mid-operation): Busy=0, counter=0, HI=0, LO=0, pending result cleared; operation is aborted with no HI/LO update.
- States: IDLE (Busy=0), RUN (Busy=1). Counter width is ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- IDLE + Start: latch the computed result into pending HI/LO; load counter = MULT_CYCLES (ops 1,2,9-12) or DIV_CYCLES (ops 3,4); go to RUN. HI/LO are not yet changed.
- RUN: counter decrements each cycle. On the edge where the counter reaches 0: HI/LO <= pending, Busy <= 0. Busy is therefore high for exactly N cycles after the start edge, and the new HI/LO are visible in the first cycle Busy=0.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV/DIVU: LO = quotient, HI = remainder; quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (both DIV and DIVU): LO = 32'hFFFF_FFFF, HI = E_RS.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- MTHI/MTLO while IDLE: HI (resp. LO) <= E_RS on the same edge, single cycle, Busy stays 0.
- MFHI/MFLO: pure read, combinational, no state change; returns the current committed HI/LO.
- Any mult/div/mt op presented while Busy=1 is ignored: Start=0, no state change. The stall logic guarantees this never occurs in normal flow; the bench checks that it stays harmless.
- E_Valid=0: treated as NOP regardless of E_MulDivOp.
- Ops 13-15: NOP.

Optional Feature:
MULDIV_MADD_EN: when defined, ops 9-12 are live. MADD/MADDU set {HI,LO} += signed/unsigned product of E_RS and E_RT; MSUB/MSUBU set {HI,LO} -= that product. Arithmetic is mod 2^64 using the HI/LO values at the start edge, with MULT_CYCLES latency and the same commit rule. When undefined, ops 9-12 are NOP: Start=0, no state change.

Test Plan:
- Reset then idle: rst low → HI=LO=0, Busy=0. Pulse rst low mid-DIV → Busy=0, HI/LO=0 immediately, with no later commit.
- MULT E_RS=32'hFFFF_FFFE (-2), E_RT=3 → Start=1, Busy=1 for 5 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. MULTU with the same operands → HI=2, LO=32'hFFFF_FFFA.
- DIV E_RS=-7 (32'hFFFF_FFF9), E_RT=2 → Busy 10 cycles, then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU 7/0 → LO=32'hFFFF_FFFF, HI=7.
- MTHI 32'h1234_5678, next cycle MFHI → MD_Out=32'h1234_5678 with Busy=0. MTLO presented during a running MULT → ignored, and LO equals the product after commit.
- E_Valid=0 with op=MULT → Start=0, Busy stays 0, HI/LO unchanged. Op=14 → no effect.
- (MULDIV_MADD_EN) HI=0, LO=32'hFFFF_FFFF, MADDU 1×1 → after 5 cycles HI=1, LO=0. Without the macro, the same stimulus leaves HI=0, LO=32'hFFFF_FFFF and Start=0.

Source files
------------

// File: rtl/e_muldiv.sv
// e_muldiv: execute-stage multiply/divide unit owning HI/LO, with a busy counter modelling latency.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 9-12); otherwise those ops are NOPs.
module e_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        E_Valid,
    input  logic [3:0]  E_MulDivOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_Out
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [63:0]   r_pend;

    logic [3:0]  w_op;
    logic        w_is_mul;
    logic        w_is_div;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_neg_rs;
    logic        w_neg_rt;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_result;

    // A squashed E-stage slot behaves exactly like a NOP.
    assign w_op = E_Valid ? E_MulDivOp : OP_NOP;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_is_mul = 1'b0;
        case (w_op)
            OP_MULT, OP_MULTU: w_is_mul = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_is_mul = 1'b1;
`endif
            default: w_is_mul = 1'b0;
        endcase
    end

    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign Busy     = (r_state == S_RUN);
    assign Start    = (w_is_mul || w_is_div) && !Busy;

    assign w_prod_s = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
    assign w_prod_u = {32'd0, E_RS} * {32'd0, E_RT};

    // Signed divide on magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0 naturally.
    assign w_neg_rs = (w_op == OP_DIV) && E_RS[31];
    assign w_neg_rt = (w_op == OP_DIV) && E_RT[31];
    assign w_num    = w_neg_rs ? -E_RS : E_RS;
    assign w_den    = (E_RT == 32'd0) ? 32'd1 : (w_neg_rt ? -E_RT : E_RT);
    assign w_uq     = w_num / w_den;
    assign w_ur     = w_num % w_den;
    assign w_q      = (w_neg_rs ^ w_neg_rt) ? -w_uq : w_uq;
    assign w_r      = w_neg_rs ? -w_ur : w_ur;

    always_comb begin
        w_result = 64'd0;
        case (w_op)
            OP_MULT:          w_result = w_prod_s;
            OP_MULTU:         w_result = w_prod_u;
            OP_DIV, OP_DIVU:  w_result = (E_RT == 32'd0) ? {E_RS, 32'hFFFF_FFFF} : {w_r, w_q};
`ifdef MULDIV_MADD_EN
            OP_MADD:          w_result = {r_hi, r_lo} + w_prod_s;
            OP_MADDU:         w_result = {r_hi, r_lo} + w_prod_u;
            OP_MSUB:          w_result = {r_hi, r_lo} - w_prod_s;
            OP_MSUBU:         w_result = {r_hi, r_lo} - w_prod_u;
`endif
            default:          w_result = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_pend  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_pend  <= w_result;
                        r_cnt   <= w_is_div ? DIV_LOAD : MULT_LOAD;
                        r_state <= S_RUN;
                    end else if (w_op == OP_MTHI) begin
                        r_hi <= E_RS;
                    end else if (w_op == OP_MTLO) begin
                        r_lo <= E_RS;
                    end
                end
                S_RUN: begin
                    // Commit on the edge where the counter reaches zero; new HI/LO appear as Busy drops.
                    if (r_cnt == CNT_ONE) begin
                        r_hi    <= r_pend[63:32];
                        r_lo    <= r_pend[31:0];
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

    always_comb begin
        MD_Out = 32'd0;
        if (w_op == OP_MFHI) MD_Out = r_hi;
        else if (w_op == OP_MFLO) MD_Out = r_lo;
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Self-checking bench for e_muldiv: arithmetic reference model plus directed literal checks.
module tb_e_muldiv;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        E_Valid    = 1'b0;
    logic [3:0]  E_MulDivOp = 4'd0;
    logic [31:0] E_RS       = 32'd0;
    logic [31:0] E_RT       = 32'd0;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MD_Out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    e_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .E_Valid(E_Valid), .E_MulDivOp(E_MulDivOp),
        .E_RS(E_RS), .E_RT(E_RT), .Start(Start), .Busy(Busy),
        .HI(HI), .LO(LO), .MD_Out(MD_Out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_starts(input logic [3:0] op);
        bit s;
        s = (op >= 4'd1 && op <= 4'd4);
`ifdef MULDIV_MADD_EN
        if (op >= 4'd9 && op <= 4'd12) s = 1'b1;
`endif
        return s;
    endfunction

    function automatic logic [63:0] m_result(input logic [3:0] op, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] hi,
                                             input logic [31:0] lo);
        int a, b;
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0] res;
        a = rs; b = rt; sa = a; sb = b;
        ua = {32'd0, rs}; ub = {32'd0, rt};
        res = 64'd0;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd3: if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
                  else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            4'd4: if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
                  else res = {32'(ua % ub), 32'(ua / ub)};
            4'd9:  res = {hi, lo} + sa * sb;
            4'd10: res = {hi, lo} + ua * ub;
            4'd11: res = {hi, lo} - sa * sb;
            4'd12: res = {hi, lo} - ua * ub;
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi <= 0; m_lo <= 0; m_phi <= 0; m_plo <= 0; m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (E_Valid) begin
            if (m_starts(E_MulDivOp)) begin
                {m_phi, m_plo} <= m_result(E_MulDivOp, E_RS, E_RT, m_hi, m_lo);
                m_left <= (E_MulDivOp == 4'd3 || E_MulDivOp == 4'd4) ? DC : MC;
            end else if (E_MulDivOp == 4'd7) begin
                m_hi <= E_RS;
            end else if (E_MulDivOp == 4'd8) begin
                m_lo <= E_RS;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        logic [31:0] exp_md;
        exp_md = 32'd0;
        if (E_Valid && E_MulDivOp == 4'd5) exp_md = m_hi;
        else if (E_Valid && E_MulDivOp == 4'd6) exp_md = m_lo;
        check("model_busy", {31'd0, Busy}, {31'd0, m_left != 0});
        check("model_start", {31'd0, Start},
              {31'd0, E_Valid && m_starts(E_MulDivOp) && m_left == 0});
        check("model_hi", HI, m_hi);
        check("model_lo", LO, m_lo);
        check("model_md_out", MD_Out, exp_md);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk);
        #1;
        E_Valid = v; E_MulDivOp = op; E_RS = rs; E_RT = rt;
    endtask

    // Present one op for one edge, then count Busy cycles (bounded) and check HI/LO at commit.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic exp_start, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        drive(1'b1, op, rs, rt);
        #1;
        check({name, "_start"}, {31'd0, Start}, {31'd0, exp_start});
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        n = 0;
        @(negedge clk);
        while (Busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, n, exp_cycles);
        check({name, "_hi"}, HI, exp_hi);
        check({name, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        #2 rst = 1'b1;

        run_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1, MC, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 4'd4, 32'd7,         32'd0, 1'b1, DC, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div0",  4'd3, 32'hFFFF_FFF0, 32'd0, 1'b1, DC, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("divovf",4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, DC, 32'h0000_0000, 32'h8000_0000);
        run_op("divu",  4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, DC, 32'h0000_0001, 32'h7FFF_FFFC);

        // MTHI then MFHI/MFLO reads
        drive(1'b1, 4'd7, 32'h1234_5678, 32'd0);
        drive(1'b1, 4'd5, 32'd0, 32'd0);
        #1;
        check("mfhi_out", MD_Out, 32'h1234_5678);
        check("mfhi_busy", {31'd0, Busy}, 32'd0);
        drive(1'b1, 4'd6, 32'd0, 32'd0);
        #1;
        check("mflo_out", MD_Out, 32'h7FFF_FFFC);

        // MTLO and a second MULT presented while busy must be ignored
        drive(1'b1, 4'd1, 32'd3, 32'd5);
        drive(1'b1, 4'd8, 32'hDEAD_BEEF, 32'd0);
        #1;
        check("mtlo_busy_start", {31'd0, Start}, 32'd0);
        drive(1'b1, 4'd1, 32'd7, 32'd7);
        #1;
        check("mult_busy_start", {31'd0, Start}, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (MC + 2) @(negedge clk);
        check("mtlo_ignored_hi", HI, 32'd0);
        check("mtlo_ignored_lo", LO, 32'd15);

        // Squashed MULT and op 14
        drive(1'b0, 4'd1, 32'd9, 32'd9);
        #1;
        check("invalid_start", {31'd0, Start}, 32'd0);
        repeat (3) @(negedge clk);
        check("invalid_busy", {31'd0, Busy}, 32'd0);
        check("invalid_lo", LO, 32'd15);
        drive(1'b1, 4'd14, 32'h5555_5555, 32'd1);
        #1;
        check("op14_start", {31'd0, Start}, 32'd0);
        check("op14_md_out", MD_Out, 32'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("op14_hi", HI, 32'd0);
        check("op14_lo", LO, 32'd15);

        // MADDU 1x1 onto HI=0, LO=FFFF_FFFF
        drive(1'b1, 4'd7, 32'd0, 32'd0);
        drive(1'b1, 4'd8, 32'hFFFF_FFFF, 32'd0);
`ifdef MULDIV_MADD_EN
        run_op("maddu", 4'd10, 32'd1, 32'd1, 1'b1, MC, 32'd1, 32'd0);
        run_op("msub",  4'd11, 32'hFFFF_FFFF, 32'd2, 1'b1, MC, 32'd1, 32'd2);
`else
        run_op("maddu", 4'd10, 32'd1, 32'd1, 1'b0, 0, 32'd0, 32'hFFFF_FFFF);
`endif

        // Reset pulse in the middle of a DIV: immediate clear, no later commit
        drive(1'b1, 4'd7, 32'hA5A5_A5A5, 32'd0);
        drive(1'b1, 4'd3, 32'd100, 32'd7);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        #1 rst = 1'b1;
        repeat (DC + 5) @(negedge clk);
        check("rst_after_busy", {31'd0, Busy}, 32'd0);
        check("rst_after_hi", HI, 32'd0);
        check("rst_after_lo", LO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
